// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 general-purpose register file.
// The in-order pipeline writeback always wins. Auxiliary multi-cycle results
// (divider, load-miss return) are buffered in a small FIFO and drained into
// idle write slots. Buffered results are marked dead when a younger pipeline
// write hits the same register. Decode can ask whether a live buffered write
// targets a source register. A starvation counter requests a pipeline bubble
// when the FIFO head keeps losing arbitration.
module regfile_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    input  logic [4:0]  query_addr,
    output logic        query_pending,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    // FIFO storage; slot validity and kill state are tracked per slot so
    // the WAW kill and the decode query are simple parallel compares.
    logic [4:0]       ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_kill;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;

    logic             pipe_req;
    logic             fifo_empty;
    logic             pop;
    logic             accept;
    logic             push;
    logic [DEPTH-1:0] kill_hit;

    // Advance a FIFO pointer, wrapping at DEPTH (which need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    // A pipeline write to r0 is not a real request: it neither blocks the FIFO nor kills.
    assign pipe_req   = pipe_we && (pipe_addr != 5'd0);
    assign fifo_empty = (count == '0);
    assign pop        = !pipe_req && !fifo_empty;

    // Ready looks only at the registered count, so a full FIFO stays closed
    // even in a cycle where the head is popped.
    assign aux_ready  = rst_n && (count < CNT_W'(DEPTH));
    assign accept     = aux_valid && aux_ready;

    // An accepted result is dropped if it targets r0 or is overwritten by a
    // concurrent (younger) pipeline write to the same register.
    assign push       = accept && (aux_addr != 5'd0) &&
                        !(pipe_we && (pipe_addr == aux_addr));

    // Mark buffered entries whose destination is being overwritten by the pipeline.
    always_comb begin
        kill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_hit[i] = pipe_req && ent_vld[i] && (ent_addr[i] == pipe_addr);
        end
    end

    // Decode RAW query: any live (valid, not killed) buffered write to query_addr.
    always_comb begin
        query_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && !ent_kill[i] && (ent_addr[i] == query_addr) &&
                (query_addr != 5'd0))
                query_pending = 1'b1;
        end
    end

    // FIFO control: pointers, occupancy, per-slot valid and kill bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_vld  <= '0;
            ent_kill <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_hit[i])
                    ent_kill[i] <= 1'b1;
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            if (push) begin
                ent_vld[tail]  <= 1'b1;
                ent_kill[tail] <= 1'b0;
                tail           <= ptr_inc(tail);
            end
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
        end
    end

    // FIFO payload; slot contents are meaningless until marked valid, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= aux_addr;
            ent_data[tail] <= aux_data;
        end
    end

    // Write-port arbitration: pipeline first, then FIFO head; a killed head still uses the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= 5'd0;
            rf_data <= 32'd0;
        end else if (pipe_req) begin
            rf_we   <= 1'b1;
            rf_addr <= pipe_addr;
            rf_data <= pipe_data;
        end else if (!fifo_empty) begin
            rf_we   <= !ent_kill[head];
            rf_addr <= ent_addr[head];
            rf_data <= ent_data[head];
        end else begin
            rf_we   <= 1'b0;
        end
    end

    // Starvation watchdog: count lost arbitrations of a waiting head, pulse pipe_stall at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            pipe_stall <= 1'b0;
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) begin
                starve_cnt <= '0;
                pipe_stall <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 general-purpose register file.
- Merges two writeback sources: the in-order pipeline writeback (priority, never back-pressured) and an auxiliary multi-cycle result source (divider, load-miss return) with a valid/ready handshake.
- Buffers auxiliary results in a small FIFO, suppresses stale results (WAW kill) and writes to r0, and exposes a pending-write query for RAW stalls.
- Drives rf_we/rf_addr/rf_data registered on posedge clk; the register file commits them on the following negedge.

Parameters:
- DEPTH, 2, auxiliary FIFO entries (1..4).
- STARVE_LIMIT, 8, consecutive cycles a valid FIFO head may lose arbitration before pipe_stall is raised.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- pipe_we  input  1  pipeline writeback request.
- pipe_addr  input  5  pipeline destination register.
- pipe_data  input  32  pipeline result.
- aux_valid  input  1  auxiliary result offered.
- aux_ready  output  1  FIFO can accept this cycle.
- aux_addr  input  5  auxiliary destination register.
- aux_data  input  32  auxiliary result.
- query_addr  input  5  source register looked up by decode.
- query_pending  output  1  a live buffered write targets query_addr.
- pipe_stall  output  1  request that the pipeline issue no writeback next cycle.
- rf_we  output  1  register-file write enable.
- rf_addr  output  5  register-file write address.
- rf_data  output  32  register-file write data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - rf_we=0, rf_addr=0, rf_data=0.
  - FIFO emptied; all kill bits cleared.
  - Starvation counter = 0; pipe_stall=0.
  - aux_ready=0 while rst_n=0.
  - Reset mid-operation discards buffered entries without writing them.
- aux_ready = (count < DEPTH), derived from registered count only; it does not account for a same-cycle pop. Accept = aux_valid & aux_ready.
- Accepted auxiliary result, at the same posedge:
  - Dropped, not enqueued, if aux_addr==0.
  - Dropped, not enqueued, if pipe_we=1 and pipe_addr==aux_addr (the auxiliary result is always older than a concurrent pipeline write).
  - Otherwise pushed at the tail with kill=0.
- WAW kill: when pipe_we=1 and pipe_addr!=0, every valid FIFO entry with addr==pipe_addr gets kill=1 at that posedge.
- Arbitration, evaluated every cycle:
  - pipe_we=1 & pipe_addr!=0: rf_* <= pipe_*, rf_we <= 1. FIFO not popped.
  - Else if the FIFO is non-empty: pop the head. rf_we <= ~head.kill, with rf_addr/rf_data from the head. A killed head still consumes the cycle.
  - Else: rf_we <= 0, rf_addr/rf_data hold their values.
  - pipe_we=1 with pipe_addr=0 counts as no request: rf_we <= 0 and the FIFO may drain.
- Latency:
  - Pipeline write: rf_we high 1 cycle after pipe_we.
  - Auxiliary write into an empty, uncontended FIFO: visible on rf_* 2 cycles after acceptance (enqueue, then pop).
- Simultaneous push and pop are allowed; count is unchanged.
- Full FIFO: aux_ready=0 and aux_valid is ignored. The source must hold aux_* stable until accepted.
- query_pending = (query_addr!=0) & OR over valid entries of (addr==query_addr & ~kill). It is combinational from registered state and excludes the same-cycle incoming auxiliary result.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and the pipeline wins.
  - Counter clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, pipe_stall <= 1 for exactly one cycle and the counter clears.
  - Upstream must drive pipe_we=0 in a cycle where pipe_stall=1. If it does not, the pipeline still wins and no write is lost.
- Entry order is strict FIFO. The head pointer wraps modulo DEPTH.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with aux_valid=1 -> rf_we=0, aux_ready=0, nothing enqueued. Release -> aux_ready=1.
- Pipeline write pipe_we=1, addr=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF. Same stimulus with addr=0 -> rf_we=0.
- Auxiliary write: aux addr=7, data=0x11 accepted with pipe idle -> query_pending(7)=1 for one cycle, rf write of (7, 0x11) 2 cycles after accept, then query_pending(7)=0.
- Back-pressure with DEPTH=2: accept (3,0xA) and (4,0xB) while pipe_we=1 to addr 9 continuously -> aux_ready=0, third offer held. Drop pipe_we -> writes (3,0xA) then (4,0xB) in order, and aux_ready returns to 1 the cycle after the first pop.
- WAW kill: buffer (6,0x1), then pipe writes (6,0x2) -> rf writes (6,0x2). The later pop of the head produces rf_we=0 and query_pending(6)=0 after the kill. A concurrent aux (8,x) with pipe (8,y) -> only y is written.
- Starvation: one buffered entry, pipe_we=1 to addr 10 for 8 cycles -> pipe_stall=1 in cycle 9. Bench drops pipe_we -> head written, counter cleared, pipe_stall returns to 0.
